// File: rtl/bp_me_pkg.sv
// Shared types for the memory-response stream-to-block assembler.
package bp_me_pkg;

    typedef enum logic [0:0] {
        e_recv = 1'b0,
        e_full = 1'b1
    } bp_me_stream_asm_state_e;

    // clog2 that never returns 0, so a single-beat block still gets a 1-bit counter.
    function automatic int bp_safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/bp_me_mem_resp_stream_to_block_if.sv
// Stream-in / block-out bundle for bp_me_mem_resp_stream_to_block.
// Handshake: a beat transfers on a clock edge where mem_resp_v_i & mem_resp_ready_and_o;
// the assembled block is taken on an edge where v_o & yumi_i.
interface bp_me_mem_resp_stream_to_block_if
    import bp_me_pkg::*;
#(
    parameter int header_width_p = 0,
    parameter int block_width_p  = 512,
    parameter int data_width_p   = 64
);
    localparam int hdr_w_lp = (header_width_p > 0) ? header_width_p : 1;

    logic [hdr_w_lp-1:0]      mem_resp_header_i;
    logic [data_width_p-1:0]  mem_resp_data_i;
    logic                     mem_resp_v_i;
    logic                     mem_resp_ready_and_o;
    logic                     mem_resp_last_i;
    logic [hdr_w_lp-1:0]      header_o;
    logic [block_width_p-1:0] data_o;
    logic                     v_o;
    logic                     yumi_i;
    logic                     overrun_o;
    bp_me_stream_asm_state_e  state_dbg_o;

    modport slave (
        input  mem_resp_header_i, mem_resp_data_i, mem_resp_v_i, mem_resp_last_i, yumi_i,
        output mem_resp_ready_and_o, header_o, data_o, v_o, overrun_o, state_dbg_o
    );

    modport master (
        output mem_resp_header_i, mem_resp_data_i, mem_resp_v_i, mem_resp_last_i, yumi_i,
        input  mem_resp_ready_and_o, header_o, data_o, v_o, overrun_o, state_dbg_o
    );

endinterface

// File: rtl/bp_me_stream_beat_counter.sv
// Saturating beat-index counter with synchronous clear (clear wins over increment).
module bp_me_stream_beat_counter #(
    parameter int width_p   = 3,
    parameter int max_val_p = 7
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               clear_i,
    input  logic               up_i,
    output logic [width_p-1:0] count_o
);
    localparam logic [width_p-1:0] max_lp = width_p'(max_val_p);

    logic [width_p-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (up_i && (cnt_q != max_lp)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/bp_me_mem_resp_stream_to_block.sv
// Assembles a 1..N dword BedRock stream response into one header plus a full
// cache block, then offers it downstream with valid/yumi. One message in flight.
module bp_me_mem_resp_stream_to_block
    import bp_me_pkg::*;
#(
    parameter int header_width_p = 0,
    parameter int block_width_p  = 512,
    parameter int data_width_p   = 64
) (
    input  logic clk_i,
    input  logic reset_n_i,
    bp_me_mem_resp_stream_to_block_if.slave bus
);
    localparam int hdr_w_lp    = (header_width_p > 0) ? header_width_p : 1;
    localparam int beats_lp    = block_width_p / data_width_p;
    localparam int lg_beats_lp = bp_safe_clog2(beats_lp);
    localparam logic [lg_beats_lp-1:0] last_slot_lp = lg_beats_lp'(beats_lp - 1);

    bp_me_stream_asm_state_e                  state_d, state_q;
    logic [hdr_w_lp-1:0]                      header_d, header_q;
    logic [beats_lp-1:0][data_width_p-1:0]    data_d, data_q;
    logic                                     overrun_d, overrun_q;

    logic [lg_beats_lp-1:0] cnt;
    logic                   ready;
    logic                   beat_fire;
    logic                   at_last_slot;
    logic                   end_of_msg;
    logic                   overrun_set;

    // Ready drops with reset itself so nothing is accepted while reset is asserted.
    assign ready        = reset_n_i && (state_q == e_recv);
    assign beat_fire    = bus.mem_resp_v_i && ready;
    assign at_last_slot = (cnt == last_slot_lp);
    assign end_of_msg   = beat_fire && (bus.mem_resp_last_i || at_last_slot);
    assign overrun_set  = beat_fire && !bus.mem_resp_last_i && at_last_slot;

    bp_me_stream_beat_counter #(
        .width_p   (lg_beats_lp),
        .max_val_p (beats_lp - 1)
    ) beat_counter (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clear_i   (end_of_msg),
        .up_i      (beat_fire),
        .count_o   (cnt)
    );

    always_comb begin
        state_d   = state_q;
        header_d  = header_q;
        data_d    = data_q;
        overrun_d = overrun_q || overrun_set;

        unique case (state_q)
            e_recv: begin
                if (beat_fire) begin
                    // First beat starts a fresh block so short messages leave upper slots zero.
                    if (cnt == '0) begin
                        header_d = bus.mem_resp_header_i;
                        data_d   = '0;
                    end
                    for (int k = 0; k < beats_lp; k++) begin
                        if (cnt == lg_beats_lp'(k)) begin
                            data_d[k] = bus.mem_resp_data_i;
                        end
                    end
                    if (end_of_msg) begin
                        state_d = e_full;
                    end
                end
            end
            e_full: begin
                if (bus.yumi_i) begin
                    state_d = e_recv;
                end
            end
            default: state_d = e_recv;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= e_recv;
            header_q  <= '0;
            data_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            header_q  <= header_d;
            data_q    <= data_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.mem_resp_ready_and_o = ready;
    assign bus.header_o             = header_q;
    assign bus.data_o               = data_q;
    assign bus.v_o                  = (state_q == e_full);
    assign bus.overrun_o            = overrun_q;
    assign bus.state_dbg_o          = state_q;

`ifndef SYNTHESIS
    yumi_only_when_valid: assert property (
        @(posedge clk_i) disable iff (!reset_n_i) bus.yumi_i |-> (state_q == e_full)
    );
`endif

endmodule

// File: tb/tb_bp_me_mem_resp_stream_to_block.sv
// Directed scoreboard bench for bp_me_mem_resp_stream_to_block.
module tb_bp_me_mem_resp_stream_to_block;
    import bp_me_pkg::*;

    localparam int hw = 32;
    localparam int bw = 512;
    localparam int dw = 64;
    localparam int nb = bw / dw;

    // ---------------- clock / reset ----------------
    logic clk_i = 1'b0;
    logic reset_n_i;
    always #5 clk_i = ~clk_i;

    bp_me_mem_resp_stream_to_block_if #(
        .header_width_p (hw),
        .block_width_p  (bw),
        .data_width_p   (dw)
    ) bus ();

    bp_me_mem_resp_stream_to_block #(
        .header_width_p (hw),
        .block_width_p  (bw),
        .data_width_p   (dw)
    ) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .bus       (bus)
    );

    // ---------------- scoreboard state ----------------
    logic [hw-1:0] exp_hdr_q[$];
    logic [bw-1:0] exp_q[$];
    logic [0:0]    exp_ovr_q[$];
    int            errors = 0;
    int            checks = 0;
    int            stall_req = 0;
    logic          exp_ovr = 1'b0;

    task automatic check(input string name, input logic [bw-1:0] act, input logic [bw-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- monitor / consumer ----------------
    initial begin
        logic          seen;
        int            stall;
        logic [hw-1:0] h_l;
        logic [bw-1:0] d_l;
        seen  = 1'b0;
        stall = 0;
        h_l   = '0;
        d_l   = '0;
        bus.yumi_i = 1'b0;
        forever begin
            @(negedge clk_i);
            if (!reset_n_i) begin
                seen       = 1'b0;
                bus.yumi_i = 1'b0;
            end else if (bus.v_o) begin
                check("full_ready_low", bus.mem_resp_ready_and_o, 0);
                if (!seen) begin
                    seen      = 1'b1;
                    stall     = stall_req;
                    stall_req = 0;
                    h_l       = bus.header_o;
                    d_l       = bus.data_o;
                    if (exp_q.size() == 0) begin
                        errors++;
                        checks++;
                        $display("FAIL unexpected_msg: got header %0h expected no message", bus.header_o);
                    end else begin
                        check("msg_header", bus.header_o, exp_hdr_q.pop_front());
                        check("msg_data", bus.data_o, exp_q.pop_front());
                        check("msg_overrun", bus.overrun_o, exp_ovr_q.pop_front());
                    end
                end else begin
                    check("stall_header_stable", bus.header_o, h_l);
                    check("stall_data_stable", bus.data_o, d_l);
                end
                if (stall > 0) begin
                    stall--;
                    bus.yumi_i = 1'b0;
                end else begin
                    bus.yumi_i = 1'b1;
                    seen       = 1'b0;
                end
            end else begin
                bus.yumi_i = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a negedge; returns just after the negedge following the transfer.
    task automatic drive_beat(input logic [hw-1:0] h, input logic [dw-1:0] d, input logic last);
        int n;
        n = 0;
        bus.mem_resp_v_i      = 1'b1;
        bus.mem_resp_header_i = h;
        bus.mem_resp_data_i   = d;
        bus.mem_resp_last_i   = last;
        while (!bus.mem_resp_ready_and_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 200) begin
            errors++;
            checks++;
            $display("FAIL beat_timeout: got ready=0 for %0d cycles expected ready=1", n);
        end else begin
            @(negedge clk_i);
        end
        bus.mem_resp_v_i    = 1'b0;
        bus.mem_resp_last_i = 1'b0;
    endtask

    task automatic send_msg(input logic [hw-1:0] h0, input logic [hw-1:0] hrest, input int n,
                            input logic [dw-1:0] beats[nb], input logic last_final);
        logic [bw-1:0] blk;
        blk = '0;
        for (int k = 0; k < n; k++) blk[k*dw +: dw] = beats[k];
        exp_hdr_q.push_back(h0);
        exp_q.push_back(blk);
        exp_ovr_q.push_back(exp_ovr);
        for (int k = 0; k < n; k++) begin
            drive_beat((k == 0) ? h0 : hrest, beats[k], (k == n - 1) ? last_final : 1'b0);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.v_o) && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 100) begin
            errors++;
            checks++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    // ---------------- stimulus ----------------
    logic [dw-1:0] beats[nb];
    logic [dw-1:0] beats_b[nb];

    initial begin
        bus.mem_resp_v_i      = 1'b0;
        bus.mem_resp_header_i = '0;
        bus.mem_resp_data_i   = '0;
        bus.mem_resp_last_i   = 1'b0;
        reset_n_i = 1'b0;

        // reset state
        #12;
        check("rst_v", bus.v_o, 0);
        check("rst_ready", bus.mem_resp_ready_and_o, 0);
        check("rst_overrun", bus.overrun_o, 0);
        check("rst_header", bus.header_o, 0);
        check("rst_data", bus.data_o, 0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        #1;
        check("post_rst_ready", bus.mem_resp_ready_and_o, 1);
        @(negedge clk_i);

        // full 8-beat block
        for (int k = 0; k < nb; k++) beats[k] = 64'h1111 * (k + 1);
        send_msg(32'hA1A1_0001, 32'hA1A1_0001, nb, beats, 1'b1);

        // short uncached read, single beat
        beats[0] = 64'hDEAD_BEEF;
        send_msg(32'h0000_0C01, 32'h0000_0C01, 1, beats, 1'b1);

        // backpressure: hold the full block 5 cycles while the next message waits
        stall_req = 5;
        for (int k = 0; k < nb; k++) beats[k] = 64'hF0F0_0000_0000_0000 | 64'(k);
        send_msg(32'hB0B0_0003, 32'hB0B0_0003, nb, beats, 1'b1);
        beats_b[0] = 64'h2222_AAAA;
        beats_b[1] = 64'h3333_BBBB;
        for (int k = 2; k < nb; k++) beats_b[k] = 64'hFFFF_FFFF_FFFF_FFFF;
        send_msg(32'hB0B0_0004, 32'hB0B0_0004, 2, beats_b, 1'b1);

        // header differs on later beats: first-beat header is kept
        for (int k = 0; k < nb; k++) beats[k] = 64'h0123_4567_0000_0000 + 64'(k * 3);
        send_msg(32'h0000_00F2, 32'h0000_00F3, nb, beats, 1'b1);
        drain();
        check("overrun_clean", bus.overrun_o, 0);

        // overrun: 8 beats without last, then a clean message keeps the sticky flag
        exp_ovr = 1'b1;
        for (int k = 0; k < nb; k++) beats[k] = 64'h5A5A_0000_0000_0000 + 64'(k);
        send_msg(32'h0000_0DD5, 32'h0000_0DD5, nb, beats, 1'b0);
        for (int k = 0; k < nb; k++) beats[k] = 64'hC0DE_0000 + 64'(k);
        send_msg(32'h0000_0EE6, 32'h0000_0EE6, 3, beats, 1'b1);
        drain();
        check("overrun_sticky", bus.overrun_o, 1);

        // async reset after 3 of 8 beats
        for (int k = 0; k < 3; k++) drive_beat(32'h7777_0007, 64'h9999_0000 + 64'(k), 1'b0);
        #3;
        reset_n_i = 1'b0;
        #1;
        check("async_rst_v", bus.v_o, 0);
        check("async_rst_ready", bus.mem_resp_ready_and_o, 0);
        check("async_rst_overrun", bus.overrun_o, 0);
        check("async_rst_data", bus.data_o, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        @(negedge clk_i);
        exp_ovr = 1'b0;
        for (int k = 0; k < nb; k++) beats[k] = 64'hABCD_0000_0000_0000 + 64'(k + 16);
        send_msg(32'h0000_0FF8, 32'h0000_0FF8, nb, beats, 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
